// File: rtl/feature_sram_arbiter.sv
// feature_sram_arbiter: shares the feature SRAM between capture, model and overlay,
// and sequences the capture -> start -> model frame phases.
module feature_sram_arbiter #(
    parameter int ADDR_LIMIT = 20000,
    parameter int TIMEOUT    = 1000000,
    parameter int DROP_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_done,
    input  logic              cap_wren,
    input  logic [15:0]       cap_addr,
    input  logic [15:0]       cap_wdata,
    input  logic              mdl_req,
    input  logic              mdl_we,
    input  logic [15:0]       mdl_addr,
    input  logic [15:0]       mdl_wdata,
    output logic              mdl_gnt,
    output logic              mdl_rvalid,
    output logic [15:0]       mdl_rdata,
    input  logic              ovl_req,
    input  logic [15:0]       ovl_addr,
    output logic              ovl_gnt,
    output logic              ovl_rvalid,
    output logic [15:0]       ovl_rdata,
    output logic              model_start,
    input  logic              model_finish,
    output logic              sram_wren,
    output logic [15:0]       sram_addr,
    output logic [15:0]       sram_wdata,
    input  logic [15:0]       sram_rdata,
    output logic [1:0]        phase,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              timeout_flag,
    output logic              addr_err
);
    typedef enum logic [1:0] {CAPTURE = 2'd0, START = 2'd1, MODEL = 2'd2} phase_t;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [15:0] LIM = 16'(ADDR_LIMIT);
    phase_t st;
    logic rr_ovl;
    logic [CW-1:0] cnt;
    logic cap_sel, acc_v, acc_we, acc_bad;
    logic [15:0] acc_addr, acc_wdata;
    logic rd_v, rd_ovl, rd_bad;
    assign phase = st;
    // Capture owns the port in CAPTURE; otherwise rr pointer (CAPTURE) or fixed mdl > ovl.
    always_comb begin
        cap_sel = st == CAPTURE && cap_wren;
        mdl_gnt = mdl_req && !cap_sel && (st != CAPTURE || !ovl_req || !rr_ovl);
        ovl_gnt = ovl_req && !cap_sel && !mdl_gnt;
        acc_v = cap_sel || mdl_gnt || ovl_gnt;
        acc_we = cap_sel || (mdl_gnt && mdl_we);
        acc_addr = cap_sel ? cap_addr : mdl_gnt ? mdl_addr : ovl_addr;
        acc_wdata = cap_sel ? cap_wdata : mdl_wdata;
        acc_bad = acc_v && acc_addr >= LIM;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= CAPTURE;
            rr_ovl <= 1'b0;
            cnt <= '0;
            sram_wren <= 1'b0;
            sram_addr <= '0;
            sram_wdata <= '0;
            rd_v <= 1'b0;
            rd_ovl <= 1'b0;
            rd_bad <= 1'b0;
            mdl_rvalid <= 1'b0;
            ovl_rvalid <= 1'b0;
            mdl_rdata <= '0;
            ovl_rdata <= '0;
            model_start <= 1'b0;
            drop_cnt <= '0;
            timeout_flag <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            sram_wren <= acc_v && !acc_bad && acc_we;
            if (acc_v && !acc_bad) begin
                sram_addr <= acc_addr;
                sram_wdata <= acc_wdata;
            end
            // Suppressed reads still travel the pipeline so the requester sees rvalid.
            rd_v <= acc_v && !acc_we;
            rd_ovl <= ovl_gnt;
            rd_bad <= acc_bad;
            mdl_rvalid <= rd_v && !rd_ovl;
            ovl_rvalid <= rd_v && rd_ovl;
            if (rd_v && !rd_ovl) mdl_rdata <= rd_bad ? '0 : sram_rdata;
            if (rd_v && rd_ovl) ovl_rdata <= rd_bad ? '0 : sram_rdata;
            if (mdl_gnt) rr_ovl <= 1'b1;
            else if (ovl_gnt) rr_ovl <= 1'b0;
            if (acc_bad) addr_err <= 1'b1;
            if (st != CAPTURE && cap_wren && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
            model_start <= st == CAPTURE && frame_done;
            case (st)
                CAPTURE: if (frame_done) st <= START;
                START: begin
                    st <= MODEL;
                    cnt <= '0;
                end
                MODEL: begin
                    if (model_finish) st <= CAPTURE;
                    else if (cnt == CW'(TIMEOUT - 1)) begin
                        st <= CAPTURE;
                        timeout_flag <= 1'b1;
                    end else cnt <= cnt + 1'b1;
                end
                default: st <= CAPTURE;
            endcase
        end
    end
endmodule

// File: tb/tb_feature_sram_arbiter.sv
// tb_feature_sram_arbiter: directed checks of arbitration, phases, timeout,
// address suppression and reset abort.
module tb_feature_sram_arbiter;
    logic clk = 0, rst_n = 0;
    logic frame_done = 0, cap_wren = 0, mdl_req = 0, mdl_we = 0, ovl_req = 0, model_finish = 0;
    logic [15:0] cap_addr = 0, cap_wdata = 0, mdl_addr = 0, mdl_wdata = 0, ovl_addr = 0;
    logic mdl_gnt, mdl_rvalid, ovl_gnt, ovl_rvalid, model_start, sram_wren, timeout_flag, addr_err;
    logic [15:0] mdl_rdata, ovl_rdata, sram_addr, sram_wdata, sram_rdata;
    logic [1:0] phase;
    logic [7:0] drop_cnt;
    int checks = 0, failures = 0;

    feature_sram_arbiter #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .frame_done(frame_done),
        .cap_wren(cap_wren), .cap_addr(cap_addr), .cap_wdata(cap_wdata),
        .mdl_req(mdl_req), .mdl_we(mdl_we), .mdl_addr(mdl_addr), .mdl_wdata(mdl_wdata),
        .mdl_gnt(mdl_gnt), .mdl_rvalid(mdl_rvalid), .mdl_rdata(mdl_rdata),
        .ovl_req(ovl_req), .ovl_addr(ovl_addr), .ovl_gnt(ovl_gnt),
        .ovl_rvalid(ovl_rvalid), .ovl_rdata(ovl_rdata),
        .model_start(model_start), .model_finish(model_finish),
        .sram_wren(sram_wren), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .phase(phase), .drop_cnt(drop_cnt),
        .timeout_flag(timeout_flag), .addr_err(addr_err)
    );

    always #5 clk = ~clk;
    assign sram_rdata = (sram_addr == 16'd5082) ? 16'h1234 : sram_addr ^ 16'hA5A5;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (2) tick();
        checks++;
        if ({mdl_gnt, ovl_gnt, mdl_rvalid, mdl_rdata, ovl_rvalid, ovl_rdata, model_start, sram_wren,
             sram_addr, sram_wdata, phase, drop_cnt, timeout_flag, addr_err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got nonzero phase=%0d sram_addr=%h drop=%0d", phase, sram_addr, drop_cnt);
        end
        rst_n = 1;
        tick();
    endtask

    task automatic test_round_robin();
        logic em, eo, emv, eov;
        mdl_we = 0;
        mdl_addr = 16'd5082;
        ovl_addr = 16'd5082;
        for (int i = 0; i < 8; i++) begin
            mdl_req = i < 6;
            ovl_req = i < 6;
            #1;
            em = i < 6 && i % 2 == 0;
            eo = i < 6 && i % 2 == 1;
            emv = i >= 2 && i % 2 == 0;
            eov = i >= 2 && i % 2 == 1;
            checks++;
            if ({mdl_gnt, ovl_gnt} !== {em, eo}) begin
                failures++;
                $display("FAIL rr_gnt cycle %0d got %b exp %b", i, {mdl_gnt, ovl_gnt}, {em, eo});
            end
            checks++;
            if ({mdl_rvalid, ovl_rvalid} !== {emv, eov}) begin
                failures++;
                $display("FAIL rr_rvalid cycle %0d got %b exp %b", i, {mdl_rvalid, ovl_rvalid}, {emv, eov});
            end
            if (i >= 2) begin
                checks++;
                if ((emv ? mdl_rdata : ovl_rdata) !== 16'h1234) begin
                    failures++;
                    $display("FAIL rr_rdata cycle %0d got %h exp 1234", i, emv ? mdl_rdata : ovl_rdata);
                end
            end
            tick();
        end
        ovl_req = 1;
        #1;
        checks++;
        if ({mdl_gnt, ovl_gnt} !== 2'b01) begin
            failures++;
            $display("FAIL single_ovl_gnt got %b exp 01", {mdl_gnt, ovl_gnt});
        end
        tick();
        ovl_req = 0;
        tick();
    endtask

    task automatic test_cap_priority();
        mdl_req = 1;
        mdl_we = 0;
        mdl_addr = 16'd100;
        for (int i = 0; i < 4; i++) begin
            cap_wren = 1;
            cap_addr = 16'(10 + i);
            cap_wdata = 16'(16'hC000 + i);
            #1;
            checks++;
            if (mdl_gnt !== 1'b0) begin
                failures++;
                $display("FAIL cap_blocks_mdl cycle %0d got %b exp 0", i, mdl_gnt);
            end
            tick();
            checks++;
            if ({sram_wren, sram_addr, sram_wdata} !== {1'b1, 16'(10 + i), 16'(16'hC000 + i)}) begin
                failures++;
                $display("FAIL cap_write %0d got %b/%h/%h exp 1/%h/%h", i, sram_wren, sram_addr, sram_wdata,
                         16'(10 + i), 16'(16'hC000 + i));
            end
        end
        cap_wren = 0;
        #1;
        checks++;
        if (mdl_gnt !== 1'b1) begin
            failures++;
            $display("FAIL mdl_gnt_after_cap got %b exp 1", mdl_gnt);
        end
        tick();
        mdl_req = 0;
        checks++;
        if ({sram_wren, sram_addr} !== {1'b0, 16'd100}) begin
            failures++;
            $display("FAIL mdl_read_issue got %b/%h exp 0/0064", sram_wren, sram_addr);
        end
        tick();
        checks++;
        if ({mdl_rvalid, mdl_rdata} !== {1'b1, 16'hA5C1}) begin
            failures++;
            $display("FAIL mdl_read_return got %b/%h exp 1/a5c1", mdl_rvalid, mdl_rdata);
        end
        tick();
    endtask

    task automatic test_phases();
        model_finish = 1;
        tick();
        model_finish = 0;
        checks++;
        if (phase !== 2'd0) begin
            failures++;
            $display("FAIL finish_in_capture phase got %0d exp 0", phase);
        end
        frame_done = 1;
        cap_wren = 1;
        cap_addr = 16'd200;
        cap_wdata = 16'h0BAD;
        tick();
        frame_done = 0;
        cap_wren = 0;
        checks++;
        if ({phase, model_start, sram_wren, sram_addr} !== {2'd1, 1'b1, 1'b1, 16'd200}) begin
            failures++;
            $display("FAIL start_phase got ph=%0d ms=%b wr=%b a=%h exp 1/1/1/00c8", phase, model_start, sram_wren, sram_addr);
        end
        tick();
        checks++;
        if ({phase, model_start} !== {2'd2, 1'b0}) begin
            failures++;
            $display("FAIL model_phase got ph=%0d ms=%b exp 2/0", phase, model_start);
        end
        mdl_req = 1;
        ovl_req = 1;
        mdl_we = 1;
        mdl_addr = 16'd400;
        mdl_wdata = 16'hBEEF;
        ovl_addr = 16'd401;
        #1;
        checks++;
        if ({mdl_gnt, ovl_gnt} !== 2'b10) begin
            failures++;
            $display("FAIL model_priority got %b exp 10", {mdl_gnt, ovl_gnt});
        end
        tick();
        mdl_req = 0;
        ovl_req = 0;
        checks++;
        if ({sram_wren, sram_addr, sram_wdata} !== {1'b1, 16'd400, 16'hBEEF}) begin
            failures++;
            $display("FAIL model_write got %b/%h/%h exp 1/0190/beef", sram_wren, sram_addr, sram_wdata);
        end
        for (int i = 0; i < 5; i++) begin
            cap_wren = 1;
            cap_addr = 16'(300 + i);
            tick();
            checks++;
            if (sram_wren !== 1'b0) begin
                failures++;
                $display("FAIL drop_no_write %0d got %b exp 0", i, sram_wren);
            end
        end
        cap_wren = 0;
        frame_done = 1;
        tick();
        frame_done = 0;
        checks++;
        if ({drop_cnt, phase, model_start} !== {8'd5, 2'd2, 1'b0}) begin
            failures++;
            $display("FAIL drop_cnt got %0d ph=%0d ms=%b exp 5/2/0", drop_cnt, phase, model_start);
        end
        model_finish = 1;
        tick();
        model_finish = 0;
        checks++;
        if (phase !== 2'd0) begin
            failures++;
            $display("FAIL finish_phase got %0d exp 0", phase);
        end
    endtask

    task automatic test_finish_at_limit();
        frame_done = 1;
        tick();
        frame_done = 0;
        tick();
        repeat (15) tick();
        checks++;
        if (phase !== 2'd2) begin
            failures++;
            $display("FAIL model_cycle15 phase got %0d exp 2", phase);
        end
        model_finish = 1;
        tick();
        model_finish = 0;
        checks++;
        if ({phase, timeout_flag} !== {2'd0, 1'b0}) begin
            failures++;
            $display("FAIL finish_at_limit got ph=%0d to=%b exp 0/0", phase, timeout_flag);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        frame_done = 1;
        tick();
        frame_done = 0;
        tick();
        while (phase == 2'd2 && n < 40) begin
            n++;
            frame_done = n == 3;
            tick();
        end
        frame_done = 0;
        checks++;
        if ({n, phase, timeout_flag} !== {32'd16, 2'd0, 1'b1}) begin
            failures++;
            $display("FAIL timeout got cycles=%0d ph=%0d to=%b exp 16/0/1", n, phase, timeout_flag);
        end
        model_finish = 1;
        tick();
        model_finish = 0;
        checks++;
        if ({phase, timeout_flag, model_start} !== {2'd0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL late_finish got ph=%0d to=%b ms=%b exp 0/1/0", phase, timeout_flag, model_start);
        end
    endtask

    task automatic test_addr_err();
        mdl_req = 1;
        mdl_we = 1;
        mdl_addr = 16'd19999;
        mdl_wdata = 16'h1111;
        tick();
        checks++;
        if ({sram_wren, sram_addr, addr_err} !== {1'b1, 16'd19999, 1'b0}) begin
            failures++;
            $display("FAIL addr_last_legal got %b/%h/%b exp 1/4e1f/0", sram_wren, sram_addr, addr_err);
        end
        mdl_addr = 16'd20000;
        mdl_wdata = 16'h7777;
        #1;
        checks++;
        if (mdl_gnt !== 1'b1) begin
            failures++;
            $display("FAIL bad_addr_gnt got %b exp 1", mdl_gnt);
        end
        tick();
        mdl_req = 0;
        checks++;
        if ({sram_wren, sram_addr, addr_err} !== {1'b0, 16'd19999, 1'b1}) begin
            failures++;
            $display("FAIL bad_addr_write got %b/%h/%b exp 0/4e1f/1", sram_wren, sram_addr, addr_err);
        end
        ovl_req = 1;
        ovl_addr = 16'd20001;
        #1;
        checks++;
        if (ovl_gnt !== 1'b1) begin
            failures++;
            $display("FAIL bad_addr_ovl_gnt got %b exp 1", ovl_gnt);
        end
        tick();
        ovl_req = 0;
        tick();
        checks++;
        if ({ovl_rvalid, ovl_rdata} !== {1'b1, 16'h0000}) begin
            failures++;
            $display("FAIL bad_addr_read got %b/%h exp 1/0000", ovl_rvalid, ovl_rdata);
        end
        tick();
    endtask

    task automatic test_reset_abort();
        logic seen = 0;
        ovl_req = 1;
        ovl_addr = 16'd50;
        tick();
        ovl_req = 0;
        rst_n = 0;
        #1;
        checks++;
        if ({mdl_gnt, ovl_gnt, mdl_rvalid, mdl_rdata, ovl_rvalid, ovl_rdata, model_start, sram_wren,
             sram_addr, sram_wdata, phase, drop_cnt, timeout_flag, addr_err} !== '0) begin
            failures++;
            $display("FAIL abort_outputs got nonzero ph=%0d drop=%0d to=%b ae=%b", phase, drop_cnt, timeout_flag, addr_err);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            seen |= ovl_rvalid;
        end
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen |= ovl_rvalid;
        end
        checks++;
        if ({seen, phase} !== {1'b0, 2'd0}) begin
            failures++;
            $display("FAIL abort_rvalid got seen=%b ph=%0d exp 0/0", seen, phase);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_cap_priority();
        test_phases();
        test_finish_at_limit();
        test_timeout();
        test_addr_err();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/feature_sram_arbiter.md
Name: feature_sram_arbiter

Overview:
- Owns the single 16-bit feature SRAM and shares it between three requesters:
  - the capture writer that produces per-block grayscale/skin/hair sums each frame;
  - the face-model engine, which reads features and writes results;
  - the overlay/display reader.
- Sequences frame phases (capture -> model start -> model run -> capture) and generates the model_start/model_finish handshake.
- Sits between the feature writer, the model and the SRAM pins.

Parameters:
- ADDR_LIMIT, 20000, first illegal SRAM word address; accesses at or above it are never issued.
- TIMEOUT, 1000000, max cycles in MODEL phase before forced return to CAPTURE.
- DROP_W, 8, width of the saturating dropped-capture-write counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_done  in  1  one-cycle pulse from capture side: feature frame complete
- cap_wren  in  1  capture write strobe (posted, never stalled)
- cap_addr  in  16  capture write address
- cap_wdata  in  16  capture write data
- mdl_req  in  1  model access request, held until granted
- mdl_we  in  1  model access is write (1) / read (0)
- mdl_addr  in  16  model address
- mdl_wdata  in  16  model write data
- mdl_gnt  out  1  model request accepted this cycle (combinational)
- mdl_rvalid  out  1  model read data valid
- mdl_rdata  out  16  model read data
- ovl_req  in  1  overlay read request, held until granted
- ovl_addr  in  16  overlay read address
- ovl_gnt  out  1  overlay request accepted this cycle (combinational)
- ovl_rvalid  out  1  overlay read data valid
- ovl_rdata  out  16  overlay read data
- model_start  out  1  one-cycle pulse: model may begin
- model_finish  in  1  one-cycle pulse: model done
- sram_wren  out  1  SRAM write enable
- sram_addr  out  16  SRAM address (registered)
- sram_wdata  out  16  SRAM write data (registered)
- sram_rdata  in  16  SRAM read data, valid same cycle as sram_addr
- phase  out  2  0 CAPTURE, 1 START, 2 MODEL
- drop_cnt  out  DROP_W  dropped capture writes, saturating
- timeout_flag  out  1  sticky: MODEL phase timed out
- addr_err  out  1  sticky: access at or above ADDR_LIMIT was suppressed

Behaviour:
- Reset values: all outputs 0; phase = CAPTURE; round-robin pointer = model. Reset mid-access aborts it; no rvalid is produced afterwards.
- Phase FSM:
  - CAPTURE: on frame_done -> START.
  - START: lasts exactly 1 cycle; model_start = 1; -> MODEL.
  - MODEL: on model_finish -> CAPTURE.
  - MODEL timeout: cycle counter cleared on MODEL entry; when it reaches TIMEOUT-1 -> CAPTURE and set timeout_flag.
  - frame_done is ignored in START and MODEL. model_finish is ignored outside MODEL.
- Arbitration in CAPTURE:
  - cap_wren has absolute priority.
  - When cap_wren = 0, mdl and ovl share the port round-robin. The winner gets gnt; the pointer moves to the other requester after each grant. A single requester wins regardless of the pointer.
- Arbitration in START/MODEL:
  - Priority is mdl > ovl.
  - cap_wren is not issued; drop_cnt increments, saturating at all-ones.
- At most one gnt per cycle. No gnt is given to a requester whose req is low.
- Issue timing: an access granted in cycle N drives sram_wren/addr/wdata registered in cycle N+1.
  - sram_wren = 1 only for writes.
  - With no access, sram_wren = 0 and addr/wdata hold their previous values.
- Read return: for a read granted in N, sram_rdata is sampled at the end of N+1. xx_rvalid = 1 for one cycle in N+2, with xx_rdata holding that value until the next rvalid.
- Back-to-back grants every cycle are legal. Read latency is fixed at 2 cycles.
- Address check: an access with addr >= ADDR_LIMIT still gets its gnt/accept but is not issued (sram_wren stays 0), and addr_err is set. A suppressed read still returns rvalid, with rdata = 0.
- Simultaneous events:
  - frame_done together with cap_wren: the write is issued, phase -> START.
  - model_finish in the same cycle the timeout fires: treated as finish; timeout_flag is not set.
- Sticky flags and drop_cnt clear only on reset.

Test Plan:
- CAPTURE, cap_wren every cycle with mdl_req held -> mdl_gnt stays 0; sram_wren = 1 each following cycle with cap_addr/cap_wdata; cap_wren deasserted -> mdl_gnt = 1 that cycle.
- CAPTURE, mdl_req and ovl_req both held, no cap -> grants alternate mdl, ovl, mdl, ovl; each read (addr 5082, SRAM model returning 16'h1234) -> rvalid 2 cycles after gnt, rdata = 16'h1234.
- frame_done pulse -> model_start = 1 for exactly the next cycle; phase goes 1 then 2; 5 cap_wren pulses in MODEL -> drop_cnt = 5, no SRAM writes; model_finish -> phase = 0.
- MODEL with no model_finish and TIMEOUT = 16 -> phase returns to 0 after 16 cycles in MODEL; timeout_flag = 1; a later model_finish has no effect.
- mdl write to addr 20000 -> mdl_gnt = 1, sram_wren stays 0, addr_err = 1; ovl read to 20001 -> rvalid with rdata = 0.
- rst_n asserted one cycle after an ovl read is granted -> ovl_rvalid never pulses; all outputs 0; phase = 0.
